// File: rtl/imem_boot_loader.sv
//------------------------------------------------------------------------------
// imem_boot_loader
//
// Byte-serial boot controller placed between an external 8-bit program port
// and the CPU core. It waits for a start marker, packs the following bytes
// little-endian into 32-bit words and writes them one after another into
// instruction memory. On the end marker it releases the core from reset,
// lets it run for RUN_CYCLES cycles, then freezes it so that results can be
// read out.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_n       synchronous active-low reset
//   byte_valid_i  byte_i is consumed this cycle
//   byte_i        serial program byte
//   imem_we_o     instruction memory write strobe (one cycle per word)
//   imem_addr_o   word address of the write
//   imem_data_o   assembled instruction word
//   cpu_rst_o     active-high reset to the core
//   cpu_en_o      core clock-enable
//   state_o       IDLE=0, LOAD=1, RUN=2, HALT=3, ERR=4
//   word_count_o  words written in the current load
//   done_o        high in HALT
//   err_o         high in ERR
//------------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int         ADDR_W     = 6,
    parameter int         RUN_CYCLES = 200,
    parameter logic [7:0] START_MK   = 8'hFE,
    parameter logic [7:0] END_MK     = 8'hFF
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_o,
    output logic              cpu_en_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HALT = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int CYC_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RUN_CYCLES - 1);
    // Memory depth expressed in word_count width: a full memory means the
    // counter has its top bit set and all lower bits clear.
    localparam logic [ADDR_W:0]  DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]       bcnt;     // byte position inside the current word
    logic [23:0]      word_lo;  // bytes 0..2 of the word being assembled
    logic [CYC_W-1:0] cyc;      // RUN cycle counter

    // Markers only count at a word boundary, where the byte would be an
    // opcode low byte; elsewhere 0xFE/0xFF are ordinary data.
    logic is_start;
    logic is_end;
    assign is_start = byte_valid_i && (bcnt == 2'd0) && (byte_i == START_MK);
    assign is_end   = byte_valid_i && (bcnt == 2'd0) && (byte_i == END_MK);

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_o      <= S_IDLE;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_data_o  <= '0;
            cpu_rst_o    <= 1'b1;
            cpu_en_o     <= 1'b0;
            word_count_o <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            bcnt         <= 2'd0;
            cyc          <= '0;
        end else begin
            // The write strobe is a single-cycle pulse.
            imem_we_o <= 1'b0;
            case (state_o)
                S_IDLE: begin
                    if (is_start) begin
                        state_o      <= S_LOAD;
                        word_count_o <= '0;
                        bcnt         <= 2'd0;
                    end
                end

                S_LOAD: begin
                    if (is_start) begin
                        word_count_o <= '0;
                    end else if (is_end) begin
                        if (word_count_o != '0) begin
                            state_o   <= S_RUN;
                            cpu_rst_o <= 1'b0;
                            cpu_en_o  <= 1'b1;
                            cyc       <= '0;
                        end else begin
                            // Empty program: the core stays in reset.
                            state_o <= S_IDLE;
                        end
                    end else if (byte_valid_i) begin
                        case (bcnt)
                            2'd0: word_lo[7:0]   <= byte_i;
                            2'd1: word_lo[15:8]  <= byte_i;
                            2'd2: word_lo[23:16] <= byte_i;
                            default: begin
                                if (word_count_o == DEPTH) begin
                                    // No room for another word: refuse it.
                                    state_o <= S_ERR;
                                    err_o   <= 1'b1;
                                end else begin
                                    imem_we_o    <= 1'b1;
                                    imem_addr_o  <= word_count_o[ADDR_W-1:0];
                                    imem_data_o  <= {byte_i, word_lo};
                                    word_count_o <= word_count_o + 1'b1;
                                end
                            end
                        endcase
                        bcnt <= bcnt + 2'd1;
                    end
                end

                S_RUN: begin
                    if (cyc == CYC_LAST) begin
                        state_o  <= S_HALT;
                        cpu_en_o <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end

                S_HALT: begin
                    // Core stays out of reset so its state can be read out.
                    if (is_start) begin
                        state_o      <= S_LOAD;
                        done_o       <= 1'b0;
                        cpu_rst_o    <= 1'b1;
                        word_count_o <= '0;
                        bcnt         <= 2'd0;
                    end
                end

                S_ERR: begin
                    // Sticky until reset_n.
                end

                default: begin
                    state_o   <= S_ERR;
                    err_o     <= 1'b1;
                    cpu_rst_o <= 1'b1;
                    cpu_en_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
//------------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed stimulus for imem_boot_loader. Expected memory writes are queued
// when the completing byte is issued; a separate monitor pops and compares
// them whenever the DUT raises imem_we_o. Control/status outputs are
// checked directly against hand-computed values.
//------------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W     = 6;
    localparam int RUN_CYCLES = 200;

    logic              clk_i = 1'b0;
    logic              reset_n = 1'b1;
    logic              byte_valid_i = 1'b0;
    logic [7:0]        byte_i = 8'h00;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic              cpu_rst_o;
    logic              cpu_en_o;
    logic [2:0]        state_o;
    logic [ADDR_W:0]   word_count_o;
    logic              done_o;
    logic              err_o;

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .RUN_CYCLES(RUN_CYCLES),
        .START_MK  (8'hFE),
        .END_MK    (8'hFF)
    ) dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .byte_valid_i(byte_valid_i),
        .byte_i      (byte_i),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_o (imem_data_o),
        .cpu_rst_o   (cpu_rst_o),
        .cpu_en_o    (cpu_en_o),
        .state_o     (state_o),
        .word_count_o(word_count_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int tests  = 0;
    int fails  = 0;
    bit mon_en = 1'b0;

    // Scoreboard entries: {addr, data}
    logic [ADDR_W+31:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor, sampling on the falling edge.
    always @(negedge clk_i) begin
        if (mon_en && imem_we_o) begin
            logic [ADDR_W+31:0] e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         imem_addr_o, imem_data_o);
            end else begin
                e = sb.pop_front();
                if ({imem_addr_o, imem_data_o} !== e) begin
                    fails++;
                    $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             imem_addr_o, imem_data_o, e[ADDR_W+31:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_i       = b;
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        sb.push_back({ADDR_W'(addr), data});
    endtask

    // Sends one word LSB first and queues the write it must produce.
    task automatic send_word(input int addr, input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        expect_write(addr, w);
        send(w[31:24]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        byte_valid_i = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_rst"},   32'(cpu_rst_o), 32'd1);
        check({tag, "_en"},    32'(cpu_en_o), 32'd0);
        check({tag, "_wc"},    32'(word_count_o), 32'd0);
        check({tag, "_done"},  32'(done_o), 32'd0);
        check({tag, "_err"},   32'(err_o), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        tick();
        check({tag, "_pending_writes"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state
        do_reset();
        mon_en = 1'b1;
        check_idle("reset");
        check("reset_we",   32'(imem_we_o), 32'd0);
        check("reset_addr", 32'(imem_addr_o), 32'd0);
        check("reset_data", imem_data_o, 32'd0);

        // ---------------- basic two-word program
        send(8'hFE);
        check("s1_state_load", 32'(state_o), 32'd1);
        send_word(0, 32'h00500513);
        send_word(1, 32'h00100593);
        check("s1_rst_before_ff", 32'(cpu_rst_o), 32'd1);
        check("s1_state_before_ff", 32'(state_o), 32'd1);
        send(8'hFF);
        check("s1_state_run", 32'(state_o), 32'd2);
        check("s1_rst_released", 32'(cpu_rst_o), 32'd0);
        check("s1_en", 32'(cpu_en_o), 32'd1);
        check("s1_wc", 32'(word_count_o), 32'd2);
        check("s1_pending_writes", 32'(sb.size()), 32'd0);

        // ---------------- run budget then HALT
        idle(RUN_CYCLES - 1);
        check("s2_still_run", 32'(state_o), 32'd2);
        check("s2_still_en", 32'(cpu_en_o), 32'd1);
        idle(1);
        check("s2_halt", 32'(state_o), 32'd3);
        check("s2_en_off", 32'(cpu_en_o), 32'd0);
        check("s2_done", 32'(done_o), 32'd1);
        check("s2_rst_low", 32'(cpu_rst_o), 32'd0);
        check("s2_wc_held", 32'(word_count_o), 32'd2);
        send(8'hFE);
        check("s2_reload_state", 32'(state_o), 32'd1);
        check("s2_reload_rst", 32'(cpu_rst_o), 32'd1);
        check("s2_reload_done", 32'(done_o), 32'd0);
        check("s2_reload_wc", 32'(word_count_o), 32'd0);

        // ---------------- valid gaps and in-word markers
        do_reset();
        send(8'hFE);
        send(8'h37);
        idle(3);
        send(8'hFF);
        send(8'hFE);
        expect_write(0, 32'h00FEFF37);
        send(8'h00);
        check("s3_still_load", 32'(state_o), 32'd1);
        send(8'hFF);
        check("s3_state_run", 32'(state_o), 32'd2);
        check("s3_wc", 32'(word_count_o), 32'd1);
        check_drained("s3");

        // ---------------- empty program
        do_reset();
        send(8'hFE);
        send(8'hFF);
        check("s4_idle", 32'(state_o), 32'd0);
        check("s4_rst", 32'(cpu_rst_o), 32'd1);
        check("s4_en", 32'(cpu_en_o), 32'd0);
        idle(2);

        // ---------------- restart inside load overwrites addr0
        send(8'hFE);
        send_word(0, 32'h11223344);
        send(8'hFE);
        check("s5_wc_restart", 32'(word_count_o), 32'd0);
        send_word(0, 32'h55667788);
        send(8'hFF);
        check("s5_state_run", 32'(state_o), 32'd2);
        check("s5_wc", 32'(word_count_o), 32'd1);
        check_drained("s5");

        // ---------------- overflow
        do_reset();
        send(8'hFE);
        for (int i = 0; i < 64; i++) send_word(i, {8'h01, 8'h5C, 8'hA0, 8'(i)});
        check("s6_wc_full", 32'(word_count_o), 32'd64);
        send(8'h40);
        send(8'hA0);
        send(8'h5C);
        send(8'h01);
        check("s6_state_err", 32'(state_o), 32'd4);
        check("s6_err", 32'(err_o), 32'd1);
        check("s6_rst", 32'(cpu_rst_o), 32'd1);
        send(8'hFF);
        check("s6_err_sticky", 32'(state_o), 32'd4);
        check("s6_en_off", 32'(cpu_en_o), 32'd0);
        check_drained("s6");
        do_reset();
        check_idle("s6_after_reset");

        // ---------------- reset mid-load
        send(8'hFE);
        send(8'hAA);
        send(8'hBB);
        do_reset();
        check_idle("s7_midload");
        send(8'hFE);
        send_word(0, 32'hDEADBE13);
        check("s7_wc", 32'(word_count_o), 32'd1);
        check_drained("s7");

        // ---------------- reset mid-run
        send(8'hFF);
        check("s8_run", 32'(state_o), 32'd2);
        idle(50);
        do_reset();
        check_idle("s8_midrun");
        send(8'hFE);
        send_word(0, 32'hCAFE0093);
        check("s8_wc", 32'(word_count_o), 32'd1);
        check_drained("s8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
